// File: rtl/i2c_codec_slave.sv
// I2C write-only target modelling the audio codec control port.
// Decodes 3-byte register writes, ACKs them, and keeps a shadow of codec registers 0x00-0x09.
module i2c_codec_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [3:0] iRD_ADDR,
    output logic [8:0] oRD_DATA,
    output logic       oWR_STB,
    output logic [6:0] oREG_ADDR,
    output logic [8:0] oREG_DATA,
    output logic       oADDR_NACK,
    output logic       oBUSY,
    output logic       oACTIVE
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
    } state_t;

    localparam int NUM_REGS = 10;

    function automatic logic [8:0] shadow_default(input int idx);
        case (idx)
            0, 1:    shadow_default = 9'h097;
            2, 3:    shadow_default = 9'h079;
            4:       shadow_default = 9'h00A;
            5:       shadow_default = 9'h008;
            6:       shadow_default = 9'h09F;
            7:       shadow_default = 9'h00A;
            default: shadow_default = 9'h000;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       sda_drive_q, sda_drive_d;
    logic       wr_stb_q, wr_stb_d;
    logic       addr_nack_q, addr_nack_d;
    logic       busy_q, busy_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic [8:0] reg_data_q, reg_data_d;
    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic [8:0] shadow_q [NUM_REGS];
    logic [8:0] shadow_d [NUM_REGS];

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] shift_next;

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA move right at an SCL edge is never a condition
    assign start_cond = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_cond  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign shift_next = {shift_q[6:0], sda_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte1_d     = byte1_q;
        sda_drive_d = sda_drive_q;
        wr_stb_d    = 1'b0;
        addr_nack_d = 1'b0;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        scl_sync_d  = {scl_sync_q[0], I2C_SCLK};
        sda_sync_d  = {sda_sync_q[0], I2C_SDAT};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = shadow_q[i];

        // The strobe cycle applies the committed write to the shadow bank
        if (wr_stb_q) begin
            if (reg_addr_q < 7'd10) begin
                shadow_d[reg_addr_q[3:0]] = reg_data_q;
            end else if (reg_addr_q == 7'h0F) begin
                for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = shadow_default(i);
            end
        end

        if (start_cond) begin
            state_d     = ADDR;
            bit_cnt_d   = 4'd0;
            busy_d      = 1'b1;
            sda_drive_d = 1'b0;
        end else if (stop_cond) begin
            state_d     = IDLE;
            bit_cnt_d   = 4'd0;
            busy_d      = 1'b0;
            sda_drive_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, BYTE1, BYTE2: begin
                    if (bit_cnt_q != 4'd8 && scl_rise) begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == ADDR && bit_cnt_q == 4'd7 &&
                            shift_next != {DEV_ADDR, 1'b0}) begin
                            addr_nack_d = 1'b1;
                            state_d     = IGNORE;
                        end
                    end else if (bit_cnt_q == 4'd8 && scl_fall) begin
                        sda_drive_d = 1'b1;
                        bit_cnt_d   = 4'd0;
                        case (state_q)
                            ADDR:    state_d = ADDR_ACK;
                            BYTE1: begin
                                state_d = ACK1;
                                byte1_d = shift_q;
                            end
                            default: state_d = ACK2;
                        endcase
                    end
                end
                ADDR_ACK, ACK1, ACK2: begin
                    // The falling edge that ends the 9th clock releases SDA
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        case (state_q)
                            ADDR_ACK: state_d = BYTE1;
                            ACK1:     state_d = BYTE2;
                            default: begin
                                state_d    = IGNORE;
                                wr_stb_d   = 1'b1;
                                reg_addr_d = byte1_q[7:1];
                                reg_data_d = {byte1_q[0], shift_q};
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            byte1_q     <= 8'd0;
            sda_drive_q <= 1'b0;
            wr_stb_q    <= 1'b0;
            addr_nack_q <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= 7'd0;
            reg_data_q  <= 9'd0;
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= shadow_default(i);
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte1_q     <= byte1_d;
            sda_drive_q <= sda_drive_d;
            wr_stb_q    <= wr_stb_d;
            addr_nack_q <= addr_nack_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    always_comb begin
        oRD_DATA = 9'd0;
        if (iRD_ADDR < 4'd10) oRD_DATA = shadow_q[iRD_ADDR];
    end

    assign I2C_SDAT   = sda_drive_q ? 1'b0 : 1'bz;
    assign oWR_STB    = wr_stb_q;
    assign oADDR_NACK = addr_nack_q;
    assign oBUSY      = busy_q;
    assign oREG_ADDR  = reg_addr_q;
    assign oREG_DATA  = reg_data_q;
    assign oACTIVE    = shadow_q[9][0];

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Directed bench for i2c_codec_slave: a bit-banged I2C master plus table-driven write/readback vectors.
module tb_i2c_codec_slave;

    localparam int Q = 8;

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic [6:0] exp_reg;
        logic [8:0] exp_data;
    } wr_vec_t;

    typedef struct {
        logic [3:0] idx;
        logic [8:0] exp_data;
    } rd_vec_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [3:0] rd_addr   = 4'd0;
    wire        sda_bus;

    logic [8:0] rd_data;
    logic       wr_stb, addr_nack, busy, active;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_pulses = 0, stb_cycles = 0, nack_pulses = 0, nack_cycles = 0, drive_cnt = 0;
    logic stb_prev = 1'b0, nack_prev = 1'b0;

    wr_vec_t init_tab [11];
    rd_vec_t def_tab  [12];
    rd_vec_t prog_tab [12];

    logic [2:0] acks;
    logic       ack_a, ack_b;
    int         s0, n0, d0;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_codec_slave dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .I2C_SCLK   (scl),
        .I2C_SDAT   (sda_bus),
        .iRD_ADDR   (rd_addr),
        .oRD_DATA   (rd_data),
        .oWR_STB    (wr_stb),
        .oREG_ADDR  (reg_addr),
        .oREG_DATA  (reg_data),
        .oADDR_NACK (addr_nack),
        .oBUSY      (busy),
        .oACTIVE    (active)
    );

    // Pulse and bus-drive bookkeeping, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_stb) stb_cycles++;
        if (wr_stb && !stb_prev) stb_pulses++;
        if (addr_nack) nack_cycles++;
        if (addr_nack && !nack_prev) nack_pulses++;
        if (sda_bus === 1'b0 && !m_sda_low) drive_cnt++;
        stb_prev  = wr_stb;
        nack_prev = addr_nack;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic ack_phase(output logic acked);
        m_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        acked = (sda_bus === 1'b0);
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_phase(acked);
    endtask

    task automatic apply_write(input logic [7:0] a, input logic [7:0] b1, input logic [7:0] b2,
                               output logic [2:0] acked);
        logic k0, k1, k2;
        i2c_start();
        write_byte(a, k0);
        write_byte(b1, k1);
        write_byte(b2, k2);
        i2c_stop();
        wait_clk(4);
        acked = {k0, k1, k2};
    endtask

    task automatic check_shadows(input int sel, input string tag);
        for (int i = 0; i < 12; i++) begin
            rd_addr = (sel == 0) ? def_tab[i].idx : prog_tab[i].idx;
            #1;
            check_output($sformatf("%s shadow[%0d]", tag, rd_addr), {23'd0, rd_data},
                         {23'd0, (sel == 0) ? def_tab[i].exp_data : prog_tab[i].exp_data});
        end
    endtask

    initial begin
        init_tab[0]  = '{8'h00, 8'h00, 7'h00, 9'h000};
        init_tab[1]  = '{8'h02, 8'h1A, 7'h01, 9'h01A};
        init_tab[2]  = '{8'h04, 8'h7B, 7'h02, 9'h07B};
        init_tab[3]  = '{8'h06, 8'h7B, 7'h03, 9'h07B};
        init_tab[4]  = '{8'h09, 8'h78, 7'h04, 9'h178};
        init_tab[5]  = '{8'h0A, 8'h06, 7'h05, 9'h006};
        init_tab[6]  = '{8'h0C, 8'h00, 7'h06, 9'h000};
        init_tab[7]  = '{8'h0E, 8'h01, 7'h07, 9'h001};
        init_tab[8]  = '{8'h10, 8'h1A, 7'h08, 9'h01A};
        init_tab[9]  = '{8'h14, 8'h55, 7'h0A, 9'h055};
        init_tab[10] = '{8'h12, 8'h01, 7'h09, 9'h001};

        def_tab[0]  = '{4'd0, 9'h097};  prog_tab[0]  = '{4'd0, 9'h000};
        def_tab[1]  = '{4'd1, 9'h097};  prog_tab[1]  = '{4'd1, 9'h01A};
        def_tab[2]  = '{4'd2, 9'h079};  prog_tab[2]  = '{4'd2, 9'h07B};
        def_tab[3]  = '{4'd3, 9'h079};  prog_tab[3]  = '{4'd3, 9'h07B};
        def_tab[4]  = '{4'd4, 9'h00A};  prog_tab[4]  = '{4'd4, 9'h178};
        def_tab[5]  = '{4'd5, 9'h008};  prog_tab[5]  = '{4'd5, 9'h006};
        def_tab[6]  = '{4'd6, 9'h09F};  prog_tab[6]  = '{4'd6, 9'h000};
        def_tab[7]  = '{4'd7, 9'h00A};  prog_tab[7]  = '{4'd7, 9'h001};
        def_tab[8]  = '{4'd8, 9'h000};  prog_tab[8]  = '{4'd8, 9'h01A};
        def_tab[9]  = '{4'd9, 9'h000};  prog_tab[9]  = '{4'd9, 9'h001};
        def_tab[10] = '{4'd10, 9'h000}; prog_tab[10] = '{4'd10, 9'h000};
        def_tab[11] = '{4'd15, 9'h000}; prog_tab[11] = '{4'd15, 9'h000};

        #2 rst_n = 1'b0;
        wait_clk(4);
        check_output("reset sda released", {31'd0, sda_bus}, 32'd1);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset wr_stb", {31'd0, wr_stb}, 32'd0);
        check_output("reset addr_nack", {31'd0, addr_nack}, 32'd0);
        check_output("reset reg_addr", {25'd0, reg_addr}, 32'd0);
        check_output("reset reg_data", {23'd0, reg_data}, 32'd0);
        check_output("reset active", {31'd0, active}, 32'd0);
        check_shadows(0, "reset");
        rst_n = 1'b1;
        wait_clk(4);

        $display("[TB] single write 34/00/1F");
        s0 = stb_pulses;
        i2c_start();
        check_output("busy after start", {31'd0, busy}, 32'd1);
        write_byte(8'h34, acks[2]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h1F, acks[0]);
        i2c_stop();
        wait_clk(4);
        check_output("w1 acks", {29'd0, acks}, 32'h7);
        check_output("w1 strobes", stb_pulses - s0, 32'd1);
        check_output("w1 reg_addr", {25'd0, reg_addr}, 32'h00);
        check_output("w1 reg_data", {23'd0, reg_data}, 32'h01F);
        check_output("busy after stop", {31'd0, busy}, 32'd0);
        rd_addr = 4'd0;
        #1;
        check_output("w1 shadow[0]", {23'd0, rd_data}, 32'h01F);

        $display("[TB] codec init sequence");
        for (int i = 0; i < 11; i++) begin
            s0 = stb_pulses;
            apply_write(8'h34, init_tab[i].b1, init_tab[i].b2, acks);
            check_output($sformatf("init[%0d] acks", i), {29'd0, acks}, 32'h7);
            check_output($sformatf("init[%0d] strobes", i), stb_pulses - s0, 32'd1);
            check_output($sformatf("init[%0d] reg_addr", i), {25'd0, reg_addr}, {25'd0, init_tab[i].exp_reg});
            check_output($sformatf("init[%0d] reg_data", i), {23'd0, reg_data}, {23'd0, init_tab[i].exp_data});
        end
        check_shadows(1, "init");
        check_output("init active", {31'd0, active}, 32'd1);

        $display("[TB] address NACK cases");
        s0 = stb_pulses;
        n0 = nack_pulses;
        d0 = drive_cnt;
        i2c_start();
        write_byte(8'h40, ack_a);
        i2c_stop();
        check_output("nack 0x40 master view", {31'd0, ack_a}, 32'd0);
        i2c_start();
        write_byte(8'h35, ack_a);
        write_byte(8'hAA, ack_b);
        i2c_stop();
        wait_clk(4);
        check_output("nack 0x35 master view", {31'd0, ack_a}, 32'd0);
        check_output("ignore data byte nack", {31'd0, ack_b}, 32'd0);
        check_output("nack pulses", nack_pulses - n0, 32'd2);
        check_output("nack strobes", stb_pulses - s0, 32'd0);
        check_output("nack sda never driven", drive_cnt - d0, 32'd0);

        $display("[TB] software reset register");
        s0 = stb_pulses;
        apply_write(8'h34, 8'h1E, 8'h00, acks);
        check_output("swrst acks", {29'd0, acks}, 32'h7);
        check_output("swrst strobes", stb_pulses - s0, 32'd1);
        check_output("swrst reg_addr", {25'd0, reg_addr}, 32'h0F);
        check_shadows(0, "swrst");
        check_output("swrst active", {31'd0, active}, 32'd0);

        $display("[TB] repeated start after BYTE1");
        s0 = stb_pulses;
        i2c_start();
        write_byte(8'h34, acks[2]);
        write_byte(8'h0E, acks[1]);
        i2c_start();
        write_byte(8'h34, acks[0]);
        check_output("rs first acks", {29'd0, acks}, 32'h7);
        write_byte(8'h12, acks[1]);
        write_byte(8'h01, acks[0]);
        i2c_stop();
        wait_clk(4);
        check_output("rs second acks", {30'd0, acks[1:0]}, 32'h3);
        check_output("rs strobes", stb_pulses - s0, 32'd1);
        check_output("rs reg_addr", {25'd0, reg_addr}, 32'h09);
        check_output("rs reg_data", {23'd0, reg_data}, 32'h001);
        rd_addr = 4'd7;
        #1;
        check_output("rs shadow[7] untouched", {23'd0, rd_data}, 32'h00A);
        check_output("rs active", {31'd0, active}, 32'd1);

        $display("[TB] reset during ACK1");
        s0 = stb_pulses;
        i2c_start();
        write_byte(8'h34, ack_a);
        for (int i = 7; i >= 1; i--) send_bit(1'b0);
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
        m_sda_low = 1'b0;
        wait_clk(3);
        check_output("ack1 drive within 3 clk", {31'd0, sda_bus}, 32'd0);
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        check_output("ack1 held while scl high", {31'd0, sda_bus}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_output("reset releases sda", {31'd0, sda_bus}, 32'd1);
        check_output("reset clears busy", {31'd0, busy}, 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        scl = 1'b0;
        wait_clk(Q);
        i2c_stop();
        wait_clk(4);
        check_shadows(0, "mid-ack reset");
        check_output("mid-ack reset active", {31'd0, active}, 32'd0);
        apply_write(8'h34, 8'h00, 8'h55, acks);
        check_output("post-reset acks", {29'd0, acks}, 32'h7);
        check_output("post-reset strobes", stb_pulses - s0, 32'd1);
        rd_addr = 4'd0;
        #1;
        check_output("post-reset shadow[0]", {23'd0, rd_data}, 32'h055);

        check_output("total strobe cycles", stb_cycles, 32'd15);
        check_output("total nack cycles", nack_cycles, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
